wb_stage: RTL and testbench
===========================

# wb_stage

Registered, handshaked write-back stage for the RV32I pipeline. It replaces the purely combinational result mux with a MEM/WB register, a load-wait state machine, and load byte/half alignment with sign or zero extension. It drives the register-file write port, a forwarding tap, and a wrapping retire counter. It sits between the memory stage and the register file.

## Interface
- XLEN, 32, datapath width. Only 32 is supported in this generation.
- REG_AW, 5, register address width.
- CNT_W, 32, retire counter width.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept an instruction
- in_reg_write  in  1  instruction writes rd
- in_rd  in  REG_AW  destination register
- in_result_src  in  2  00 ALU, 01 MEM, 10 PC+4, 11 IMM
- in_alu_result  in  XLEN  ALU result; for loads, the effective address
- in_pc_plus4  in  XLEN  link value
- in_imm  in  XLEN  immediate (LUI)
- in_funct3  in  3  load width/sign
- mem_rvalid  in  1  load data valid
- mem_rdata  in  XLEN  raw aligned word from data memory
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_AW  write address
- rf_wdata  out  XLEN  write data
- fwd_valid, fwd_rd, fwd_data  out  1/REG_AW/XLEN  copy of the pending write for the hazard unit
- retire  out  1  one-cycle pulse per completed instruction
- retire_cnt  out  CNT_W  completed-instruction count
- load_misalign  out  1  one-cycle trap pulse (macro-dependent)

## Operation
- States:
  - IDLE: in_ready=1.
  - WAIT_LOAD: in_ready=0.
- Accept = in_valid & in_ready.
- Non-load accept (src≠01): the selected value is registered and rf_we, rf_waddr and rf_wdata are driven the next cycle. The FSM stays in IDLE. Throughput is one instruction per cycle.
- Load accept (src=01): the instruction is latched and the FSM enters WAIT_LOAD. mem_rvalid is sampled only in WAIT_LOAD; a mem_rvalid in the accept cycle is ignored. When mem_rvalid arrives, the extended data is registered, the write occurs the next cycle, and the FSM returns to IDLE.
- Load extension uses addr_lo = in_alu_result[1:0]:
  - 000 LB: sign-extend byte[addr_lo].
  - 001 LH: sign-extend half[addr_lo[1]].
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extend.
  - Any other funct3 writes 0.
- rd=0 or in_reg_write=0: rf_we stays 0, but the instruction still retires.
- fwd_* mirrors rf_* in the same cycle. fwd_valid = rf_we.
- retire pulses in the same cycle as the write slot. retire_cnt increments by 1 and wraps from all-ones to 0.
- Reset mid-load: return to IDLE and discard the outstanding response. A late mem_rvalid arriving while in IDLE is ignored.

## Timing
- Reset values:
  - state=IDLE, in_ready=1.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - fwd_valid=0, fwd_rd=0, fwd_data=0.
  - retire=0, retire_cnt=0, load_misalign=0.
- Latency:
  - Non-load: accept at cycle N, write at N+1.
  - Load: write one cycle after the mem_rvalid sample.
- All outputs are registered. in_ready is decoded from the state register only; there is no combinational path from inputs.

## Configuration
- WB_LOAD_MISALIGN_TRAP_EN defined:
  - Misalignment is LH/LHU with addr_lo[0]=1, or LW with addr_lo≠0.
  - The check is made at accept; no memory wait occurs.
  - The write is suppressed and load_misalign pulses in the slot where the write would have been.
  - The instruction retires (retire pulses, retire_cnt increments).
- Undefined:
  - Misaligned low bits are masked (LH uses addr_lo[1]; LW ignores addr_lo).
  - load_misalign is tied to 0.

## Structure
- Package wb_pkg holds:
  - the result_src enum (RES_ALU, RES_MEM, RES_PC4, RES_IMM);
  - load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU);
  - the state enum (S_IDLE, S_WAIT_LOAD).
- Sub-module load_ext: combinational align/extend of (mem_rdata, funct3, addr_lo), instantiated once.

## Test plan
- Back-to-back ALU instructions (rd=5, 0xAAAABBBB), then IMM (rd=6, 0x12345000), then PC+4 (rd=1, 0x100) on consecutive cycles -> three consecutive rf_we pulses with matching data; retire_cnt=3.
- Load LB, addr=0x...3, mem_rdata=0x80345678 delivered 3 cycles after accept -> in_ready low 3 cycles, rf_wdata=0xFFFFFF80. Repeat with LBU -> 0x00000080.
- LHU addr_lo=2, rdata=0x9ABC1234 -> 0x00009ABC. LH with the same inputs -> 0xFFFF9ABC.
- ALU write to rd=0 -> rf_we=0, retire=1, retire_cnt increments.
- Reset asserted in WAIT_LOAD, then mem_rvalid after release -> no write, IDLE, counter 0.
- LW addr_lo=1:
  - Macro defined: load_misalign=1, rf_we=0, retire=1.
  - Macro undefined: waits for mem_rvalid, then writes the full word.
  - Also force retire_cnt to 0xFFFFFFFF and retire one instruction -> 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the RV32I write-back stage.
// The misalignment helper is only referenced when WB_LOAD_MISALIGN_TRAP_EN is defined.
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } state_t;

  // Halfwords must sit on an even address, words on a word-aligned one.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if ((f3 == F3_LH) || (f3 == F3_LHU)) mis = addr_lo[0];
    else if (f3 == F3_LW)                mis = (addr_lo != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/wb_stage_load_ext.sv
// Combinational load alignment: picks the addressed byte/half of the raw word
// and sign- or zero-extends it; unknown funct3 yields zero.
module load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Low address bits beyond the access size are simply ignored here.
  assign byte_sel = rdata_i[8*addr_lo_i +: 8];
  assign half_sel = rdata_i[16*addr_lo_i[1] +: 16];

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LW:   data_o = rdata_i;
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Registered MEM/WB stage: result select, load wait FSM, register-file write port,
// forwarding tap and retire counter. WB_LOAD_MISALIGN_TRAP_EN enables the misaligned-load trap.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [1:0]        in_result_src,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_pc_plus4,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [2:0]        in_funct3,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data,
  output logic              retire,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic              load_misalign
);

  state_t            state_q, state_d;
  logic              ld_we_q, ld_we_d;
  logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
  logic [2:0]        ld_f3_q, ld_f3_d;
  logic [1:0]        ld_lo_q, ld_lo_d;

  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic              retire_q, retire_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              mis_q, mis_d;

  logic              accept;
  logic              wr_ok;
  logic [XLEN-1:0]   ext_data;
  result_src_t       src;

  assign src      = result_src_t'(in_result_src);
  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid & in_ready;
  assign wr_ok    = in_reg_write & (in_rd != '0);

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .rdata_i  (mem_rdata),
    .funct3_i (ld_f3_q),
    .addr_lo_i(ld_lo_q),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    ld_we_d    = ld_we_q;
    ld_rd_d    = ld_rd_q;
    ld_f3_d    = ld_f3_q;
    ld_lo_d    = ld_lo_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    retire_d   = 1'b0;
    mis_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (src == RES_MEM) begin
`ifdef WB_LOAD_MISALIGN_TRAP_EN
            if (is_misaligned(in_funct3, in_alu_result[1:0])) begin
              retire_d   = 1'b1;
              mis_d      = 1'b1;
              rf_waddr_d = in_rd;
            end else
`endif
            begin
              state_d = S_WAIT_LOAD;
              ld_we_d = wr_ok;
              ld_rd_d = in_rd;
              ld_f3_d = in_funct3;
              ld_lo_d = in_alu_result[1:0];
            end
          end else begin
            retire_d   = 1'b1;
            rf_we_d    = wr_ok;
            rf_waddr_d = in_rd;
            case (src)
              RES_PC4: rf_wdata_d = in_pc_plus4;
              RES_IMM: rf_wdata_d = in_imm;
              default: rf_wdata_d = in_alu_result;
            endcase
          end
        end
      end
      S_WAIT_LOAD: begin
        // Response data only counts once the load is outstanding.
        if (mem_rvalid) begin
          state_d    = S_IDLE;
          retire_d   = 1'b1;
          rf_we_d    = ld_we_q;
          rf_waddr_d = ld_rd_q;
          rf_wdata_d = ext_data;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ld_we_q    <= 1'b0;
      ld_rd_q    <= '0;
      ld_f3_q    <= '0;
      ld_lo_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      retire_q   <= 1'b0;
      cnt_q      <= '0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_we_q    <= ld_we_d;
      ld_rd_q    <= ld_rd_d;
      ld_f3_q    <= ld_f3_d;
      ld_lo_q    <= ld_lo_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      retire_q   <= retire_d;
      mis_q      <= mis_d;
      if (retire_d) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign rf_we         = rf_we_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign fwd_valid     = rf_we_q;
  assign fwd_rd        = rf_waddr_q;
  assign fwd_data      = rf_wdata_q;
  assign retire        = retire_q;
  assign retire_cnt    = cnt_q;
  assign load_misalign = mis_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus randomized instruction stream
// compared against an arithmetic reference model; honours WB_LOAD_MISALIGN_TRAP_EN.
module tb_wb_stage;
  localparam int TB_CNT_W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_reg_write = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [1:0]  in_result_src = '0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_pc_plus4 = '0;
  logic [31:0] in_imm = '0;
  logic [2:0]  in_funct3 = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        retire;
  logic [TB_CNT_W-1:0] retire_cnt;
  logic        load_misalign;

  int total = 0;
  int bad = 0;
  int cnt_m = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_result_src(in_result_src),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4), .in_imm(in_imm),
    .in_funct3(in_funct3), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire(retire), .retire_cnt(retire_cnt), .load_misalign(load_misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference load result from the byte/half selection rules, using plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
    longint unsigned b, h, a;
    a = longint'(lo);
    b = (longint'(w) / (64'd1 << (8 * a))) % 256;
    h = (longint'(w) / (64'd1 << (16 * (a / 2)))) % 65536;
    case (f3)
      3'd0: return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
      3'd1: return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
      3'd2: return w;
      3'd4: return 32'(b);
      3'd5: return 32'(h);
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_mis(input logic [2:0] f3, input logic [1:0] lo);
`ifdef WB_LOAD_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (int'(lo) % 2 == 1)) return 1'b1;
    if (f3 == 3'd2 && lo != 2'd0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Called at #1 after a rising edge; returns #1 after the write-slot edge.
  task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] src,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                       input logic [2:0] f3, input logic [31:0] rdata, input int dly,
                       input bit rv_early);
    logic [31:0] ev;
    bit mis, ew;
    mis = 1'b0;
    case (src)
      2'd0: ev = alu;
      2'd2: ev = pc4;
      2'd3: ev = imm;
      default: begin
        ev  = ref_load(f3, alu[1:0], rdata);
        mis = ref_mis(f3, alu[1:0]);
      end
    endcase
    ew = rw && (rd != 5'd0) && !mis;
    in_valid = 1'b1; in_reg_write = rw; in_rd = rd; in_result_src = src;
    in_alu_result = alu; in_pc_plus4 = pc4; in_imm = imm; in_funct3 = f3;
    mem_rvalid = rv_early; mem_rdata = ~rdata;
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; mem_rvalid = 1'b0;
    if (src == 2'd1 && !mis) begin
      for (int i = 1; i < dly; i++) begin
        chk("wait_ready", 32'(in_ready), 32'd0);
        chk("wait_we", 32'(rf_we), 32'd0);
        chk("wait_retire", 32'(retire), 32'd0);
        @(posedge clk); #1;
      end
      chk("wait_ready_last", 32'(in_ready), 32'd0);
      mem_rvalid = 1'b1; mem_rdata = rdata;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end
    cnt_m = (cnt_m + 1) % (1 << TB_CNT_W);
    chk("rf_we", 32'(rf_we), 32'(ew));
    chk("fwd_valid", 32'(fwd_valid), 32'(ew));
    if (ew) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(rd));
      chk("rf_wdata", rf_wdata, ev);
      chk("fwd_rd", 32'(fwd_rd), 32'(rd));
      chk("fwd_data", fwd_data, ev);
    end
    chk("retire", 32'(retire), 32'd1);
    chk("retire_cnt", 32'(retire_cnt), 32'(cnt_m));
    chk("load_misalign", 32'(load_misalign), 32'(mis));
    chk("ready_after", 32'(in_ready), 32'd1);
    $display("txn src=%0d f3=%0d rd=%0d we=%0d data=%h mis=%0d cnt=%0d", src, f3, rd, ew, ev, mis, cnt_m);
  endtask

  task automatic idle(input bit late_rv);
    in_valid = 1'b0; mem_rvalid = late_rv; mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("idle_we", 32'(rf_we), 32'd0);
    chk("idle_retire", 32'(retire), 32'd0);
    chk("idle_mis", 32'(load_misalign), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd1);
    chk("idle_cnt", 32'(retire_cnt), 32'(cnt_m));
  endtask

  initial begin
    logic [2:0] f3_tab [6];
    logic [1:0] s;
    f3_tab[0] = 3'd0; f3_tab[1] = 3'd1; f3_tab[2] = 3'd2;
    f3_tab[3] = 3'd4; f3_tab[4] = 3'd5; f3_tab[5] = 3'd3;

    #2;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_fwd", {fwd_valid, 26'd0, fwd_rd}, 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_cnt", 32'(retire_cnt), 32'd0);
    chk("rst_mis", 32'(load_misalign), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1'b0);

    // Back-to-back ALU, IMM, PC+4.
    issue(1, 5'd5, 2'd0, 32'hAAAABBBB, 32'h4, 32'h0, 3'd0, 32'h0, 1, 0);
    issue(1, 5'd6, 2'd3, 32'h0, 32'h8, 32'h12345000, 3'd0, 32'h0, 1, 0);
    issue(1, 5'd1, 2'd2, 32'h0, 32'h100, 32'h0, 3'd0, 32'h0, 1, 0);
    chk("b2b_cnt", 32'(retire_cnt), 32'd3);
    idle(1'b0);

    issue(1, 5'd7, 2'd1, 32'h00001003, 32'h0, 32'h0, 3'd0, 32'h80345678, 3, 1);
    chk("lb_const", rf_wdata, 32'hFFFFFF80);
    issue(1, 5'd7, 2'd1, 32'h00001003, 32'h0, 32'h0, 3'd4, 32'h80345678, 3, 0);
    chk("lbu_const", rf_wdata, 32'h00000080);
    issue(1, 5'd8, 2'd1, 32'h00002002, 32'h0, 32'h0, 3'd5, 32'h9ABC1234, 2, 0);
    chk("lhu_const", rf_wdata, 32'h00009ABC);
    issue(1, 5'd8, 2'd1, 32'h00002002, 32'h0, 32'h0, 3'd1, 32'h9ABC1234, 1, 1);
    chk("lh_const", rf_wdata, 32'hFFFF9ABC);
    issue(1, 5'd0, 2'd0, 32'h12345678, 32'h0, 32'h0, 3'd0, 32'h0, 1, 0);
    issue(1, 5'd9, 2'd1, 32'h00003001, 32'h0, 32'h0, 3'd2, 32'hCAFEF00D, 2, 0);
    idle(1'b1);

    // Reset while a load is outstanding, then a stale response.
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 5'd10; in_result_src = 2'd1;
    in_alu_result = 32'h0; in_funct3 = 3'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_ready", 32'(in_ready), 32'd0);
    #3 rst_n = 1'b0;
    #1;
    cnt_m = 0;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_cnt", 32'(retire_cnt), 32'd0);
    chk("mid_rst_we", 32'(rf_we), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1'b1);
    idle(1'b0);

    for (int n = 0; n < 150; n++) begin
      s = 2'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 31)), s,
            $urandom, $urandom, $urandom, f3_tab[$urandom_range(0, 5)], $urandom,
            $urandom_range(1, 4), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
    end

    // Drive the counter up to all-ones, then across the wrap.
    while (cnt_m != (1 << TB_CNT_W) - 1)
      issue(1, 5'd3, 2'd0, $urandom, 32'h0, 32'h0, 3'd0, 32'h0, 1, 0);
    issue(1, 5'd4, 2'd0, $urandom, 32'h0, 32'h0, 3'd0, 32'h0, 1, 0);
    chk("wrap_cnt", 32'(retire_cnt), 32'd0);
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
